hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_match.sv | 33 +++
 rtl/hazard_forward_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults, forwarding-select encoding and the in-flight tracker entry type
// for the operand hazard/forwarding unit.
package hazard_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int DEPTH_DEF  = 3;
  // Tracker rd field is sized for the widest supported register address.
  localparam int REG_W_MAX  = 8;

  localparam logic [2:0] SEL_RF = 3'd0;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 we;
    logic                 is_load;
  } tracker_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Priority matcher for one source register against the in-flight tracker;
// the nearest (lowest-index) valid writer of the register wins.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int RD_W  = REG_W_MAX
) (
  input  logic [RD_W-1:0]       src_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [DEPTH-1:0]      we_i,
  input  logic [DEPTH-1:0]      load_i,
  input  logic [DEPTH*RD_W-1:0] rd_i,
  output logic                  hit_o,
  output logic [2:0]            idx_o,
  output logic                  is_load_o
);

  always_comb begin
    hit_o     = 1'b0;
    idx_o     = 3'd0;
    is_load_o = 1'b0;
    // Scan from the oldest stage so the youngest producer overwrites last.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_i[k] && we_i[k] && (rd_i[k*RD_W +: RD_W] == src_i) && (src_i != '0)) begin
        hit_o     = 1'b1;
        idx_o     = 3'(k);
        is_load_o = load_i[k];
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage operand resolution: tracks in-flight writers, forwards results
// from later stages, and stalls on load-use (or on any hazard when forwarding is off).
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    fwd_en,
  input  logic                    id_valid,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic [REG_W-1:0]        id_rs1,
  input  logic [REG_W-1:0]        id_rs2,
  input  logic [REG_W-1:0]        id_rd,
  input  logic [DATA_W-1:0]       rf_a,
  input  logic [DATA_W-1:0]       rf_b,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic [2:0]              fwd_sel_a,
  output logic [2:0]              fwd_sel_b,
  output logic                    stall,
  output logic [15:0]             stall_count
);

  tracker_entry_t [DEPTH-1:0] trk_q, trk_d;
  logic [15:0]                stall_count_q, stall_count_d;

  logic [DEPTH-1:0]           v_vec, we_vec, ld_vec;
  logic [DEPTH*REG_W_MAX-1:0] rd_vec;

  always_comb begin
    v_vec  = '0;
    we_vec = '0;
    ld_vec = '0;
    rd_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_vec[k]                          = trk_q[k].valid;
      we_vec[k]                         = trk_q[k].we;
      ld_vec[k]                         = trk_q[k].is_load;
      rd_vec[k*REG_W_MAX +: REG_W_MAX]  = trk_q[k].rd;
    end
  end

  logic       hit_a, hit_b, ld_a, ld_b;
  logic [2:0] idx_a, idx_b;

  hazard_match #(.DEPTH(DEPTH), .RD_W(REG_W_MAX)) u_match_a (
    .src_i     (REG_W_MAX'(id_rs1)),
    .valid_i   (v_vec),
    .we_i      (we_vec),
    .load_i    (ld_vec),
    .rd_i      (rd_vec),
    .hit_o     (hit_a),
    .idx_o     (idx_a),
    .is_load_o (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH), .RD_W(REG_W_MAX)) u_match_b (
    .src_i     (REG_W_MAX'(id_rs2)),
    .valid_i   (v_vec),
    .we_i      (we_vec),
    .load_i    (ld_vec),
    .rd_i      (rd_vec),
    .hit_o     (hit_b),
    .idx_o     (idx_b),
    .is_load_o (ld_b)
  );

  logic stall_a, stall_b;

  // A hit that cannot be forwarded (load still in EX, or forwarding disabled)
  // falls back to the register file and requests a stall.
  always_comb begin
    op_a      = rf_a;
    fwd_sel_a = SEL_RF;
    stall_a   = 1'b0;
    if (hit_a) begin
      if (!fwd_en || (idx_a == 3'd0 && ld_a)) begin
        stall_a = 1'b1;
      end else begin
        op_a      = stage_result[int'(idx_a)*DATA_W +: DATA_W];
        fwd_sel_a = idx_a + 3'd1;
      end
    end
  end

  always_comb begin
    op_b      = rf_b;
    fwd_sel_b = SEL_RF;
    stall_b   = 1'b0;
    if (hit_b) begin
      if (!fwd_en || (idx_b == 3'd0 && ld_b)) begin
        stall_b = 1'b1;
      end else begin
        op_b      = stage_result[int'(idx_b)*DATA_W +: DATA_W];
        fwd_sel_b = idx_b + 3'd1;
      end
    end
  end

  assign stall = id_valid && !flush && (stall_a || stall_b);

  always_comb begin
    trk_d = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      trk_d[k] = trk_q[k-1];
    end
    if (id_valid && !stall && !flush) begin
      trk_d[0].valid   = 1'b1;
      trk_d[0].rd      = REG_W_MAX'(id_rd);
      trk_d[0].we      = id_we;
      trk_d[0].is_load = id_is_load;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trk_q         <= '0;
      stall_count_q <= 16'd0;
    end else begin
      trk_q         <= trk_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a cycle-by-cycle vector table plus
// hand sequences for load-use, stall-only mode and reset during a stall.
module tb_hazard_forward_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush, fwd_en, id_valid, id_we, id_is_load;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] rf_a, rf_b, sr0, sr1, sr2;
  logic [47:0] stage_result;
  logic [15:0] op_a, op_b;
  logic [2:0]  fwd_sel_a, fwd_sel_b;
  logic        stall;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign stage_result = {sr2, sr1, sr0};

  hazard_forward_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .fwd_en       (fwd_en),
    .id_valid     (id_valid),
    .id_we        (id_we),
    .id_is_load   (id_is_load),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .rf_a         (rf_a),
    .rf_b         (rf_b),
    .stage_result (stage_result),
    .op_a         (op_a),
    .op_b         (op_b),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  typedef struct {
    logic        v, we, ld, fl;
    logic [3:0]  rs1, rs2, rd;
    logic [15:0] s0, s1, s2;
    logic [15:0] e_a, e_b;
    logic [2:0]  e_sa, e_sb;
    logic        e_st;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic v, logic we, logic ld, logic fl,
                              logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd,
                              logic [15:0] s0, logic [15:0] e_a, logic [15:0] e_b,
                              logic [2:0] e_sa, logic [2:0] e_sb, logic e_st);
    vec_t r;
    r.v = v; r.we = we; r.ld = ld; r.fl = fl;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.s0 = s0; r.s1 = 16'h5A5A; r.s2 = 16'h2222;
    r.e_a = e_a; r.e_b = e_b; r.e_sa = e_sa; r.e_sb = e_sb; r.e_st = e_st;
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [15:0] ea, logic [15:0] eb,
                         logic [2:0] esa, logic [2:0] esb, logic est);
    chk({tag, " op_a"},      op_a, ea);
    chk({tag, " op_b"},      op_b, eb);
    chk({tag, " fwd_sel_a"}, 16'(fwd_sel_a), 16'(esa));
    chk({tag, " fwd_sel_b"}, 16'(fwd_sel_b), 16'(esb));
    chk({tag, " stall"},     16'(stall), 16'(est));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic v, logic we, logic ld, logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd);
    id_valid = v; id_we = we; id_is_load = ld;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;
    reset_n = 1'b0;
    flush = 1'b0; fwd_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    rf_a = 16'hAAAA; rf_b = 16'hBBBB;
    sr0 = 16'h00A5; sr1 = 16'h5A5A; sr2 = 16'h2222;

    // Reset state, with a valid decode reading non-zero registers.
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd3, 4'd5, 4'd3);
    #2;
    chk_out("reset", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b0);
    chk("reset stall_count", stall_count, 16'd0);
    tick();
    chk("reset held stall_count", stall_count, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    reset_n = 1'b1;

    // v  we ld fl rs1 rs2 rd  s0        op_a      op_b      sa sb st
    tbl[0]  = mk(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 16'h00A5, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 4'd1, 4'd2, 4'd3, 16'h00A5, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 4'd3, 4'd4, 4'd3, 16'h00A5, 16'h00A5, 16'hBBBB, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 4'd3, 4'd3, 4'd3, 16'h00A5, 16'h5A5A, 16'h5A5A, 2, 2, 0);
    tbl[4]  = mk(1, 0, 0, 0, 4'd3, 4'd6, 4'd0, 16'h1111, 16'h1111, 16'hBBBB, 1, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 0, 4'd1, 4'd2, 4'd5, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 4'd1, 4'd5, 4'd0, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 4'd1, 4'd5, 4'd0, 16'h1111, 16'hAAAA, 16'h5A5A, 0, 2, 0);
    tbl[10] = mk(1, 1, 1, 0, 4'd1, 4'd2, 4'd7, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 4'd7, 4'd0, 4'd0, 16'h1111, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 4'd7, 4'd0, 4'd0, 16'h1111, 16'h5A5A, 16'hBBBB, 2, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
      flush = tbl[i].fl;
      sr0 = tbl[i].s0; sr1 = tbl[i].s1; sr2 = tbl[i].s2;
      #2;
      chk_out($sformatf("vec%0d", i), tbl[i].e_a, tbl[i].e_b, tbl[i].e_sa, tbl[i].e_sb, tbl[i].e_st);
      tick();
    end
    flush = 1'b0;
    chk("table stall_count", stall_count, 16'd0);

    // Load-use: one stall cycle, then forward from stage 1.
    pulse_reset();
    fwd_en = 1'b1;
    sr1 = 16'h7E7E;
    drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 4'd5);
    #2;
    chk("lu issue stall", 16'(stall), 16'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd5, 4'd9);
    #2;
    chk_out("lu stalled", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b1);
    chk("lu stalled count", stall_count, 16'd0);
    tick();
    #2;
    chk_out("lu fwd", 16'hAAAA, 16'h7E7E, 3'd0, 3'd2, 1'b0);
    chk("lu fwd count", stall_count, 16'd1);
    tick();
    chk("lu after count", stall_count, 16'd1);

    // Stall-only mode: producer of r2 must drain through all three stages.
    pulse_reset();
    fwd_en = 1'b0;
    sr0 = 16'h0C0C;
    drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd3, 4'd2);
    #2;
    chk("so issue stall", 16'(stall), 16'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd4, 4'd0);
    #2;
    chk_out("so first", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b1);
    fwd_en = 1'b1;
    #1;
    chk_out("so fwd_en on", 16'h0C0C, 16'hBBBB, 3'd1, 3'd0, 1'b0);
    fwd_en = 1'b0;
    #1;
    chk("so fwd_en off stall", 16'(stall), 16'd1);
    stalls = 0;
    for (int c = 0; c < 10 && stall; c++) begin
      stalls++;
      tick();
      #2;
    end
    chk("so stall cycles", 16'(stalls), 16'd3);
    chk_out("so drained", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b0);
    chk("so stall_count", stall_count, 16'd3);
    tick();

    // Reset asserted in the middle of a load-use stall.
    fwd_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 4'd5);
    #2;
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd0);
    #2;
    chk("rst pre stall", 16'(stall), 16'd1);
    chk("rst pre count", stall_count, 16'd3);
    reset_n = 1'b0;
    #1;
    chk_out("rst asserted", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b0);
    chk("rst asserted count", stall_count, 16'd0);
    reset_n = 1'b1;
    #1;
    chk("rst released stall", 16'(stall), 16'd0);
    tick();
    #2;
    chk_out("rst after edge", 16'hAAAA, 16'hBBBB, 3'd0, 3'd0, 1'b0);
    chk("rst after edge count", stall_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
